vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator; replaces fixed-size VGA timing with full per-axis timing,
//  sync polarity, pixel-clock divider, run enable and line/frame strobes. Feeds pixel pipelines and DAC/HDMI glue.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line         | V_ACTIVE  480  visible lines per frame
//  H_FP      16   h front porch (pixels)          | V_FP      10   v front porch (lines)
//  H_SYNC    96   h sync width (pixels)           | V_SYNC    2    v sync width (lines)
//  H_BP      48   h back porch (pixels)           | V_BP      33   v back porch (lines)
//  H_POL     0    hsync active level              | V_POL     0    vsync active level
//  H_BITS    10   col/counter width               | V_BITS    10   row/counter width
//  PIX_DIV   1    clk cycles per pixel (>=1)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous, active-low reset
//  en           in   1       run enable; 0 freezes raster position
//  hsync        out  1       horizontal sync, active level H_POL
//  vsync        out  1       vertical sync, active level V_POL
//  disp_ena     out  1       1 while in visible area
//  n_blank      out  1       equals disp_ena
//  col          out  H_BITS  current visible column
//  row          out  V_BITS  current visible row
//  line_start   out  1       1-tick strobe at h position 0
//  frame_start  out  1       1-tick strobe at position (0,0)
// BEHAVIOUR
//  - H_PERIOD=H_ACTIVE+H_FP+H_SYNC+H_BP; V_PERIOD likewise. Axis order: active, FP, sync, BP.
//  - Tick: divider counts 0..PIX_DIV-1 while en=1; tick when divider==PIX_DIV-1 (PIX_DIV=1: every en cycle).
//    en=0: divider, counters and all outputs hold; line_start/frame_start forced 0.
//  - On tick: outputs <= decode(h,v); then h<=h+1, at H_PERIOD-1 wraps to 0 and v advances; v wraps at V_PERIOD-1.
//    Latency: outputs describe position (h,v) one tick after counter holds it; all outputs mutually aligned.
//  - decode: hsync=H_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL; vsync same on v.
//    disp_ena=n_blank=(h<H_ACTIVE)&&(v<V_ACTIVE). col<=h when h<H_ACTIVE, row<=v when v<V_ACTIVE, else hold.
//    line_start=(h==0); frame_start=(h==0)&&(v==0).
//  - Reset (rst=0, async): h=v=0, divider=0, hsync=~H_POL, vsync=~V_POL, disp_ena=n_blank=0, col=row=0,
//    line_start=frame_start=0. First tick after release emits (0,0): disp_ena=1, line_start=frame_start=1.
//  - Reset mid-frame: immediate return to reset values; no partial strobes.
//  - Elaboration errors: any timing param 0 except porches; PIX_DIV<1; H_PERIOD>2**H_BITS; V_PERIOD>2**V_BITS.
//  - Counters never exceed PERIOD-1; no arithmetic beyond counter width.
// STRUCTURE
//  - Package vga_timing_pkg: default 640x480 timing constants, period/threshold helper functions.
//  - Sub-module vga_axis_counter (period/FP/sync/active params; inc in, wrap out, in_active/in_sync out),
//    instantiated twice: horizontal (inc=tick) and vertical (inc=tick & h wrap).
// TESTING (H 4/1/2/1 -> period 8, V 3/1/1/1 -> period 6, H_POL=0, V_POL=1, PIX_DIV=1 unless stated)
//  - Reset release, en=1: tick1 frame_start=1,col=0,row=0,disp_ena=1; hsync=0 on ticks 6-7 only; period 8.
//  - Full frame: frame_start every 48 ticks; vsync=1 only on lines v=4; disp_ena 12 of 48 ticks.
//  - Blanking: during h=4..7 col holds 3; during v=3..5 row holds 2; disp_ena=0.
//  - en low 5 cycles at h=2: outputs frozen, strobes 0; resumes at h=3 with no skipped position.
//  - PIX_DIV=3: outputs change every 3rd clk; line period 24 clks; frame 144 clks.
//  - rst asserted mid-line (h=5,v=2): outputs go to reset values without clk edge; restart at (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and helpers shared by the timing generator and its axis counters.
package vga_timing_pkg;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;
    localparam int unsigned DefBits    = 10;

    function automatic int unsigned axis_period(input int unsigned active, input int unsigned fp,
                                                input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
        return active + fp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: run enable towards the generator; sync, blanking, position and strobes back out.
interface vga_timing_gen_if #(
    parameter int unsigned H_BITS = 10,
    parameter int unsigned V_BITS = 10
);
    logic              en;
    logic              hsync;
    logic              vsync;
    logic              disp_ena;
    logic              n_blank;
    logic [H_BITS-1:0] col;
    logic [V_BITS-1:0] row;
    logic              line_start;
    logic              frame_start;

    modport master (
        input  en,
        output hsync, vsync, disp_ena, n_blank, col, row, line_start, frame_start
    );

    modport slave (
        output en,
        input  hsync, vsync, disp_ena, n_blank, col, row, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and sync-region decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DefHActive,
    parameter int unsigned FP     = DefHFp,
    parameter int unsigned SYNC   = DefHSync,
    parameter int unsigned BP     = DefHBp,
    parameter int unsigned BITS   = DefBits
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    output logic [BITS-1:0] cnt_o,
    output logic            wrap_o,
    output logic            in_active_o,
    output logic            in_sync_o
);
    localparam int unsigned Period = axis_period(ACTIVE, FP, SYNC, BP);
    localparam int unsigned SyncLo = sync_start(ACTIVE, FP);
    localparam int unsigned SyncHi = SyncLo + SYNC;
    localparam logic [BITS-1:0] Last = BITS'(Period - 1);

    logic [BITS-1:0] cnt_q, cnt_d;
    logic [31:0]     cnt_ext;

    // Decode in 32 bits: the sync end may equal 2**BITS, which the counter width cannot hold.
    assign cnt_ext     = 32'(cnt_q);
    assign wrap_o      = (cnt_q == Last);
    assign in_active_o = (cnt_ext < ACTIVE);
    assign in_sync_o   = (cnt_ext >= SyncLo) && (cnt_ext < SyncHi);
    assign cnt_o       = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; outputs describe the position held one tick earlier.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned H_BITS   = DefBits,
    parameter int unsigned V_BITS   = DefBits,
    parameter int unsigned PIX_DIV  = 1
) (
    input logic              clk_i,
    input logic              rst_ni,
    vga_timing_gen_if.master vga_io
);
    if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0 || H_BITS == 0 ||
        V_BITS == 0) begin : g_err_zero
        $error("vga_timing_gen: zero-sized timing parameter");
    end
    if (PIX_DIV < 1) begin : g_err_div
        $error("vga_timing_gen: PIX_DIV must be at least 1");
    end
    if (64'(axis_period(H_ACTIVE, H_FP, H_SYNC, H_BP)) > (64'd1 << H_BITS)) begin : g_err_h
        $error("vga_timing_gen: H period does not fit in H_BITS");
    end
    if (64'(axis_period(V_ACTIVE, V_FP, V_SYNC, V_BP)) > (64'd1 << V_BITS)) begin : g_err_v
        $error("vga_timing_gen: V period does not fit in V_BITS");
    end

    localparam int unsigned DivW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(PIX_DIV - 1);

    logic [DivW-1:0]   div_q, div_d;
    logic              tick;
    logic [H_BITS-1:0] h_cnt;
    logic [V_BITS-1:0] v_cnt;
    logic              h_wrap, h_active, h_sync;
    logic              v_wrap, v_active, v_sync;
    logic              unused_v_wrap;

    logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic              ls_q, ls_d, fs_q, fs_d;
    logic [H_BITS-1:0] col_q, col_d;
    logic [V_BITS-1:0] row_q, row_d;

    assign tick          = vga_io.en && (div_q == DivLast);
    assign unused_v_wrap = v_wrap;

    always_comb begin
        div_d = div_q;
        if (vga_io.en) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .BITS   (H_BITS)
    ) u_h_axis (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (tick),
        .cnt_o       (h_cnt),
        .wrap_o      (h_wrap),
        .in_active_o (h_active),
        .in_sync_o   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .BITS   (V_BITS)
    ) u_v_axis (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (tick && h_wrap),
        .cnt_o       (v_cnt),
        .wrap_o      (v_wrap),
        .in_active_o (v_active),
        .in_sync_o   (v_sync)
    );

    // Strobes are cleared while paused so a resume cannot replay a stale strobe.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        col_d   = col_q;
        row_d   = row_q;
        ls_d    = ls_q;
        fs_d    = fs_q;
        if (tick) begin
            hsync_d = h_sync ? H_POL : ~H_POL;
            vsync_d = v_sync ? V_POL : ~V_POL;
            de_d    = h_active && v_active;
            col_d   = h_active ? h_cnt : col_q;
            row_d   = v_active ? v_cnt : row_q;
            ls_d    = (h_cnt == '0);
            fs_d    = (h_cnt == '0) && (v_cnt == '0);
        end else if (!vga_io.en) begin
            ls_d = 1'b0;
            fs_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign vga_io.hsync       = hsync_q;
    assign vga_io.vsync       = vsync_q;
    assign vga_io.disp_ena    = de_q;
    assign vga_io.n_blank     = de_q;
    assign vga_io.col         = col_q;
    assign vga_io.row         = row_q;
    assign vga_io.line_start  = ls_q && vga_io.en;
    assign vga_io.frame_start = fs_q && vga_io.en;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: 8x6 raster at PIX_DIV 1 and 3 against a position-index reference model.
module tb_vga_timing_gen;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HP = HA + HF + HS + HB;
    localparam int VP = VA + VF + VS + VB;
    localparam int FRAME = HP * VP;
    localparam int HBITS = 3, VBITS = 3;

    logic clk = 1'b0;
    logic rst_ni;
    logic en;
    int   n_assert = 0;
    int   n_fail = 0;

    // Reference state: pos is the raster index the counters hold; outputs show the previous one.
    int   pos[2];
    int   divc[2];
    logic m_hs[2], m_vs[2], m_de[2], m_ls[2], m_fs[2];
    int   m_col[2], m_row[2];

    always #5 clk = ~clk;

    vga_timing_gen_if #(.H_BITS(HBITS), .V_BITS(VBITS)) bus0 ();
    vga_timing_gen_if #(.H_BITS(HBITS), .V_BITS(VBITS)) bus1 ();

    assign bus0.en = en;
    assign bus1.en = en;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .H_POL (1'b0), .V_POL (1'b1), .H_BITS (HBITS), .V_BITS (VBITS), .PIX_DIV (1)
    ) dut0 (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .vga_io (bus0)
    );

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .H_POL (1'b0), .V_POL (1'b1), .H_BITS (HBITS), .V_BITS (VBITS), .PIX_DIV (3)
    ) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .vga_io (bus1)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL dut%0d %s: observed %0d expected %0d", k, tag, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        pos[k]   = 0;
        divc[k]  = 0;
        m_hs[k]  = 1'b1;
        m_vs[k]  = 1'b0;
        m_de[k]  = 1'b0;
        m_ls[k]  = 1'b0;
        m_fs[k]  = 1'b0;
        m_col[k] = 0;
        m_row[k] = 0;
    endtask

    task automatic model_clock(input int k, input int div, input logic en_v);
        int h, v;
        if (!en_v) begin
            m_ls[k] = 1'b0;
            m_fs[k] = 1'b0;
            return;
        end
        divc[k]++;
        if (divc[k] < div) return;
        divc[k] = 0;
        h = pos[k] % HP;
        v = pos[k] / HP;
        m_hs[k] = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
        m_vs[k] = (v >= VA + VF && v < VA + VF + VS) ? 1'b1 : 1'b0;
        m_de[k] = (h < HA) && (v < VA);
        if (h < HA) m_col[k] = h;
        if (v < VA) m_row[k] = v;
        m_ls[k] = (h == 0);
        m_fs[k] = (pos[k] == 0);
        pos[k]  = (pos[k] + 1) % FRAME;
    endtask

    task automatic check_dut(input int k, input logic hs, input logic vs, input logic de,
                             input logic nb, input logic ls, input logic fs,
                             input logic [31:0] col, input logic [31:0] row);
        chk("hsync", k, 32'(hs), 32'(m_hs[k]));
        chk("vsync", k, 32'(vs), 32'(m_vs[k]));
        chk("disp_ena", k, 32'(de), 32'(m_de[k]));
        chk("n_blank", k, 32'(nb), 32'(m_de[k]));
        chk("line_start", k, 32'(ls), 32'(m_ls[k] & en));
        chk("frame_start", k, 32'(fs), 32'(m_fs[k] & en));
        chk("col", k, col, 32'(m_col[k]));
        chk("row", k, row, 32'(m_row[k]));
    endtask

    task automatic check_all();
        check_dut(0, bus0.hsync, bus0.vsync, bus0.disp_ena, bus0.n_blank, bus0.line_start,
                  bus0.frame_start, 32'(bus0.col), 32'(bus0.row));
        check_dut(1, bus1.hsync, bus1.vsync, bus1.disp_ena, bus1.n_blank, bus1.line_start,
                  bus1.frame_start, 32'(bus1.col), 32'(bus1.row));
    endtask

    task automatic step(input logic en_v);
        en = en_v;
        @(posedge clk);
        #1;
        model_clock(0, 1, en_v);
        model_clock(1, 3, en_v);
        check_all();
    endtask

    // Called just after a clock edge: checks the asynchronous effect before the next edge.
    task automatic do_reset();
        en = 1'b0;
        rst_ni = 1'b0;
        #2;
        model_reset(0);
        model_reset(1);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_ni = 1'b1;
    endtask

    initial begin
        int de_cnt, fs_cnt, vs_cnt, guard;
        rst_ni = 1'b1;
        en = 1'b0;
        #2;
        do_reset();

        // First tick after release shows (0,0).
        step(1'b1);
        chk("first frame_start", 0, 32'(bus0.frame_start), 32'd1);
        chk("first col", 0, 32'(bus0.col), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        // Reset mid-line with the counters at h=5, v=2.
        guard = 0;
        while (pos[0] != 2 * HP + 5 && guard < 200) begin
            step(1'b1);
            guard++;
        end
        chk("reach h5v2 within budget", 0, 32'(guard < 200), 32'd1);
        do_reset();

        de_cnt = 0;
        fs_cnt = 0;
        vs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1);
            de_cnt += int'(bus0.disp_ena);
            fs_cnt += int'(bus0.frame_start);
            vs_cnt += int'(bus0.vsync);
        end
        chk("frame disp_ena count", 0, 32'(de_cnt), 32'd12);
        chk("frame frame_start count", 0, 32'(fs_cnt), 32'd1);
        chk("frame vsync count", 0, 32'(vs_cnt), 32'd8);

        // Pause with outputs showing h=2, then resume at h=3.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("pre-pause col", 0, 32'(bus0.col), 32'd2);
        for (int i = 0; i < 5; i++) step(1'b0);
        chk("paused col", 0, 32'(bus0.col), 32'd2);
        step(1'b1);
        chk("resume col", 0, 32'(bus0.col), 32'd3);

        for (int i = 0; i < 2 * 3 * FRAME; i++) begin
            step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
